// File: rtl/rv32i_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mc_ctrl (plus its select-encoding package rv32i_pkg)
// Purpose  : Multi-cycle RV32I control unit. Sequences instruction fetch,
//            decode/execute, data-memory access and retire, and drives the
//            datapath selects and write strobes.
// Ports    : clk_i, rst_ni                     clock, async active-low reset
//            instr_req_o/instr_gnt_i/instr_rvalid_i/instr_i   fetch handshake
//            br_taken_i                        branch comparator result
//            data_req_o/data_we_o/data_gnt_i/data_rvalid_i    data handshake
//            ir_we_o, pc_we_o, rf_we_o         IR / PC / regfile strobes
//            a_sel_o .. pc_sel_o               datapath selects (rv32i_pkg)
//            illegal_o                         sticky illegal-opcode flag
//            minstret_o                        retired-instruction counter
// Revision : 1.0  initial release
// ============================================================================

package rv32i_pkg;
  localparam int ASEL_W   = 2;
  localparam int BSEL_W   = 1;
  localparam int ALUSEL_W = 4;
  localparam int IMMSEL_W = 3;
  localparam int WBSEL_W  = 2;
  localparam int PCSEL_W  = 1;

  typedef enum logic [ASEL_W-1:0]   {A_REG = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} asel_e;
  typedef enum logic [BSEL_W-1:0]   {B_REG = 1'b0, B_IMM = 1'b1} bsel_e;
  typedef enum logic [ALUSEL_W-1:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR   = 4'd8, ALU_AND = 4'd9
  } alusel_e;
  typedef enum logic [IMMSEL_W-1:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } immsel_e;
  typedef enum logic [WBSEL_W-1:0]  {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wbsel_e;
  typedef enum logic [PCSEL_W-1:0]  {PC_4 = 1'b0, PC_ALU = 1'b1} pcsel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
endpackage

module rv32i_mc_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_i,
  input  logic        br_taken_i,
  output logic        data_req_o,
  output logic        data_we_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        rf_we_o,
  output asel_e       a_sel_o,
  output bsel_e       b_sel_o,
  output alusel_e     alu_sel_o,
  output immsel_e     imm_sel_o,
  output wbsel_e      wb_sel_o,
  output pcsel_e      pc_sel_o,
  output logic        illegal_o,
  output logic [31:0] minstret_o
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_WAIT_I   = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MEM_REQ  = 3'd3;
  localparam logic [2:0] S_MEM_WAIT = 3'd4;
  localparam logic [2:0] S_TRAP     = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  // Cleared by reset and set on the first clock edge after release, so the
  // fetch request is held low while reset is active and rises on that edge.
  logic        started;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        illegal_q;
  logic [31:0] retire_cnt;

  logic        is_store;
  logic        op_legal;
  alusel_e     alu_fn;

  // Only opcode, funct3 and funct7[5] steer control; the rest of the
  // instruction word belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // --------------------------------------------------------------------------
  // Decode helpers on the latched IR fields
  // --------------------------------------------------------------------------
  always_comb begin
    is_store = (opcode == OPC_STORE);
    op_legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_FENCE, OPC_LOAD, OPC_STORE: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // SUB exists only for register-register ops; SRA is selected by f7[5] for
  // both OP and OP-IMM (imm[10] sits in that bit position).
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_FETCH;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (started && instr_gnt_i) state_nxt = S_WAIT_I;
      S_WAIT_I:   if (instr_rvalid_i)         state_nxt = S_EXEC;
      S_EXEC: begin
        if (!op_legal)                                    state_nxt = S_TRAP;
        else if (opcode == OPC_LOAD || opcode == OPC_STORE) state_nxt = S_MEM_REQ;
        else                                              state_nxt = S_FETCH;
      end
      S_MEM_REQ:  if (data_gnt_i)    state_nxt = is_store ? S_FETCH : S_MEM_WAIT;
      S_MEM_WAIT: if (data_rvalid_i) state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    instr_req_o = 1'b0;
    ir_we_o     = 1'b0;
    data_req_o  = 1'b0;
    data_we_o   = 1'b0;
    rf_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    a_sel_o     = A_REG;
    b_sel_o     = B_REG;
    alu_sel_o   = ALU_ADD;
    imm_sel_o   = IMM_I;
    wb_sel_o    = WB_ALU;
    pc_sel_o    = PC_4;
    case (state)
      S_FETCH:  instr_req_o = started;
      S_WAIT_I: ir_we_o     = instr_rvalid_i;
      S_EXEC: begin
        case (opcode)
          OPC_OP: begin
            alu_sel_o = alu_fn;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_OP_IMM: begin
            b_sel_o   = B_IMM;
            alu_sel_o = alu_fn;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_LUI: begin
            a_sel_o   = A_ZERO;
            b_sel_o   = B_IMM;
            imm_sel_o = IMM_U;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_AUIPC: begin
            a_sel_o   = A_PC;
            b_sel_o   = B_IMM;
            imm_sel_o = IMM_U;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_JAL: begin
            a_sel_o   = A_PC;
            b_sel_o   = B_IMM;
            imm_sel_o = IMM_J;
            pc_sel_o  = PC_ALU;
            wb_sel_o  = WB_PC;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_JALR: begin
            b_sel_o   = B_IMM;
            pc_sel_o  = PC_ALU;
            wb_sel_o  = WB_PC;
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
          end
          OPC_BRANCH: begin
            a_sel_o   = A_PC;
            b_sel_o   = B_IMM;
            imm_sel_o = IMM_B;
            pc_sel_o  = br_taken_i ? PC_ALU : PC_4;
            pc_we_o   = 1'b1;
          end
          OPC_FENCE: pc_we_o = 1'b1;
          OPC_LOAD:  b_sel_o = B_IMM;
          OPC_STORE: begin
            b_sel_o   = B_IMM;
            imm_sel_o = IMM_S;
          end
          default: ;
        endcase
      end
      // Address selects stay on rs1+imm while the memory access is pending.
      S_MEM_REQ: begin
        data_req_o = 1'b1;
        data_we_o  = is_store;
        b_sel_o    = B_IMM;
        imm_sel_o  = is_store ? IMM_S : IMM_I;
        pc_we_o    = is_store && data_gnt_i;
      end
      S_MEM_WAIT: begin
        b_sel_o  = B_IMM;
        wb_sel_o = WB_MEM;
        rf_we_o  = data_rvalid_i;
        pc_we_o  = data_rvalid_i;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // IR fields, sticky illegal flag, retire counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode     <= 7'd0;
      funct3     <= 3'd0;
      funct7_b5  <= 1'b0;
      illegal_q  <= 1'b0;
      retire_cnt <= 32'd0;
    end else begin
      if (ir_we_o) begin
        opcode    <= instr_i[6:0];
        funct3    <= instr_i[14:12];
        funct7_b5 <= instr_i[30];
      end
      if (state == S_EXEC && !op_legal) illegal_q <= 1'b1;
      if (pc_we_o) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign illegal_o  = illegal_q;
  assign minstret_o = retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mc_ctrl
// Purpose  : Self-checking bench for rv32i_mc_ctrl. A memory responder drives
//            the fetch/data handshakes with random latencies and random
//            instructions; expected strobes/selects come from an instruction
//            table model and a retire counter kept here.
// Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_mc_ctrl;
  import rv32i_pkg::*;

  localparam int K_SEQ   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_ILL   = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_i;
  logic        br_taken_i;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic        ir_we_o, pc_we_o, rf_we_o;
  asel_e       a_sel_o;
  bsel_e       b_sel_o;
  alusel_e     alu_sel_o;
  immsel_e     imm_sel_o;
  wbsel_e      wb_sel_o;
  pcsel_e      pc_sel_o;
  logic        illegal_o;
  logic [31:0] minstret_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [6:0]  legal [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111,
                              7'b0000011, 7'b0100011};

  rv32i_mc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_i        (instr_i),
    .br_taken_i     (br_taken_i),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .rf_we_o        (rf_we_o),
    .a_sel_o        (a_sel_o),
    .b_sel_o        (b_sel_o),
    .alu_sel_o      (alu_sel_o),
    .imm_sel_o      (imm_sel_o),
    .wb_sel_o       (wb_sel_o),
    .pc_sel_o       (pc_sel_o),
    .illegal_o      (illegal_o),
    .minstret_o     (minstret_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {instr_req, ir_we, data_req, data_we, rf_we, pc_we}
  function automatic logic [31:0] stb_now();
    return {26'd0, instr_req_o, ir_we_o, data_req_o, data_we_o, rf_we_o, pc_we_o};
  endfunction

  // {a, b, alu, imm, wb, pc}; bits [12:3] are the address-forming selects
  function automatic logic [31:0] sel_now();
    return {19'd0, a_sel_o, b_sel_o, alu_sel_o, imm_sel_o, wb_sel_o, pc_sel_o};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-class table: what the EXEC cycle must show for this word.
  function automatic void model_exec(input logic [31:0] ins, input logic br,
                                     output logic [12:0] sel, output logic [5:0] stb,
                                     output int kind);
    asel_e   a;
    bsel_e   b;
    alusel_e alu;
    immsel_e imm;
    wbsel_e  wb;
    pcsel_e  pc;
    logic    rf, pcw;
    logic [2:0] f3;
    alusel_e tab [8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3  = ins[14:12];
    a = A_REG; b = B_REG; alu = ALU_ADD; imm = IMM_I; wb = WB_ALU; pc = PC_4;
    rf = 1'b0; pcw = 1'b1; kind = K_SEQ;
    case (ins[6:0])
      7'b0110011: begin
        rf = 1'b1; alu = tab[f3];
        if (ins[30] && f3 == 3'd0) alu = ALU_SUB;
        if (ins[30] && f3 == 3'd5) alu = ALU_SRA;
      end
      7'b0010011: begin
        rf = 1'b1; b = B_IMM; alu = tab[f3];
        if (ins[30] && f3 == 3'd5) alu = ALU_SRA;
      end
      7'b0110111: begin rf = 1'b1; a = A_ZERO; b = B_IMM; imm = IMM_U; end
      7'b0010111: begin rf = 1'b1; a = A_PC;   b = B_IMM; imm = IMM_U; end
      7'b1101111: begin rf = 1'b1; a = A_PC; b = B_IMM; imm = IMM_J; pc = PC_ALU; wb = WB_PC; end
      7'b1100111: begin rf = 1'b1; b = B_IMM; pc = PC_ALU; wb = WB_PC; end
      7'b1100011: begin a = A_PC; b = B_IMM; imm = IMM_B; pc = br ? PC_ALU : PC_4; end
      7'b0001111: ;
      7'b0000011: begin b = B_IMM; pcw = 1'b0; kind = K_LOAD; end
      7'b0100011: begin b = B_IMM; imm = IMM_S; pcw = 1'b0; kind = K_STORE; end
      default:    begin pcw = 1'b0; kind = K_ILL; end
    endcase
    sel = {a, b, alu, imm, wb, pc};
    stb = {4'b0000, rf, pcw};
  endfunction

  task automatic step(input logic ig, input logic irv, input logic [31:0] ins,
                      input logic dg, input logic drv, input logic br);
    @(negedge clk);
    instr_gnt_i = ig; instr_rvalid_i = irv; instr_i = ins;
    data_gnt_i = dg; data_rvalid_i = drv; br_taken_i = br;
    #1;
  endtask

  // Runs one instruction through fetch/exec/memory with the given latencies
  // (cycles of wait before gnt/rvalid). Leaves the DUT one cycle into the
  // next fetch, or in EXEC's successor for an illegal opcode.
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic br,
                           input int gd, input int rd, input int dg, input int dr);
    logic [12:0] esel;
    logic [5:0]  estb;
    int          kind;
    logic [12:0] msel;
    model_exec(ins, br, esel, estb, kind);
    for (int i = 0; i <= gd; i++) begin
      step(i == gd, (i == gd) ? 1'b0 : rbit(), $urandom, rbit(), 1'b0, rbit());
      chk({nm, "_fetch"}, stb_now(), 32'h20);
    end
    for (int i = 0; i <= rd; i++) begin
      step(rbit(), i == rd, (i == rd) ? ins : $urandom, rbit(), 1'b0, rbit());
      chk({nm, "_waiti"}, stb_now(), (i == rd) ? 32'h10 : 32'h0);
    end
    step(rbit(), rbit(), $urandom, rbit(), 1'b0, br);
    chk({nm, "_exec_stb"}, stb_now(), 32'(estb));
    chk({nm, "_exec_sel"}, sel_now(), 32'(esel));
    if (kind == K_ILL) return;
    if (kind == K_LOAD || kind == K_STORE) begin
      msel = {A_REG, B_IMM, ALU_ADD, (kind == K_STORE) ? IMM_S : IMM_I, WB_ALU, PC_4};
      for (int i = 0; i <= dg; i++) begin
        step(rbit(), rbit(), $urandom, i == dg, 1'b0, rbit());
        chk({nm, "_memreq_stb"}, stb_now(),
            {26'd0, 2'b00, 1'b1, kind == K_STORE, 1'b0, (kind == K_STORE) && (i == dg)});
        chk({nm, "_memreq_sel"}, sel_now(), 32'(msel));
      end
      if (kind == K_LOAD) begin
        for (int i = 0; i <= dr; i++) begin
          step(rbit(), rbit(), $urandom, rbit(), i == dr, rbit());
          chk({nm, "_memwait_stb"}, stb_now(), (i == dr) ? 32'h3 : 32'h0);
          if (i == dr)
            chk({nm, "_memwait_sel"}, sel_now(),
                32'({A_REG, B_IMM, ALU_ADD, IMM_I, WB_MEM, PC_4}));
          else
            chk({nm, "_memwait_addr"}, 32'(sel_now() >> 3),
                32'({A_REG, B_IMM, ALU_ADD, IMM_I}));
        end
      end
    end
    exp_cnt = exp_cnt + 32'd1;
    step(1'b0, 1'b0, $urandom, rbit(), 1'b0, rbit());
    chk({nm, "_next_req"}, stb_now(), 32'h20);
    chk({nm, "_minstret"}, minstret_o, exp_cnt);
    chk({nm, "_illegal"}, 32'(illegal_o), 32'd0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_ni = 1'b0; instr_gnt_i = 1'b1; #1;
    exp_cnt = 32'd0;
    chk({nm, "_rst_stb"}, stb_now(), 32'h0);
    chk({nm, "_rst_illegal"}, 32'(illegal_o), 32'd0);
    chk({nm, "_rst_minstret"}, minstret_o, exp_cnt);
    step(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    chk({nm, "_rst_hold"}, stb_now(), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    chk({nm, "_req_after_rst"}, stb_now(), 32'h20);
  endtask

  initial begin
    logic [31:0] ins;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_i = 32'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; br_taken_i = 1'b0;

    do_reset("por");

    // ADD x3,x1,x2 with immediate handshakes: 3-cycle instruction
    run_instr("add", 32'h002081B3, 1'b0, 0, 0, 0, 0);

    // LW x2,0(x1): data gnt after 2 wait cycles, rvalid the cycle after gnt
    run_instr("lw", 32'h0000A103, 1'b0, 0, 0, 2, 0);

    // SW x2,4(x1) and SUB/SRAI variants
    run_instr("sw",   32'h0020A223, 1'b0, 0, 0, 0, 0);
    run_instr("sub",  32'h402081B3, 1'b0, 1, 1, 0, 0);
    run_instr("srai", 32'h4030D193, 1'b0, 0, 2, 0, 0);
    run_instr("addi_f7", 32'h40308193, 1'b0, 0, 0, 0, 0);

    // BEQ taken, then not taken
    run_instr("beq_t", 32'h00208463, 1'b1, 0, 0, 0, 0);
    run_instr("beq_n", 32'h00208463, 1'b0, 0, 0, 0, 0);

    // Random legal instructions with random handshake latencies
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[6:0] = legal[$urandom_range(0, 9)];
      run_instr("rand", ins, rbit(), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Retire counter wraps from all-ones to zero
    @(negedge clk);
    instr_gnt_i = 1'b0;
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_preload", minstret_o, exp_cnt);
    run_instr("wrap", 32'h002081B3, 1'b0, 0, 0, 0, 0);
    chk("wrap_zero", minstret_o, 32'd0);

    // Reset while a load waits for its data
    do_reset("pre_mw");
    step(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    chk("mw_idle", stb_now(), 32'h0);
    @(negedge clk);
    rst_ni = 1'b0; data_rvalid_i = 1'b1; #1;
    exp_cnt = 32'd0;
    chk("mw_rst_stb", stb_now(), 32'h0);
    chk("mw_rst_minstret", minstret_o, exp_cnt);
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    chk("mw_rst_hold", stb_now(), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    chk("mw_late_rvalid", stb_now(), 32'h20);
    chk("mw_late_minstret", minstret_o, exp_cnt);
    run_instr("mw_restart", 32'h002081B3, 1'b0, 0, 0, 0, 0);

    // Illegal opcode traps and stays there until reset
    run_instr("ill", 32'h00000073, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(rbit(), rbit(), $urandom, rbit(), rbit(), rbit());
      chk("trap_stb", stb_now(), 32'h0);
      chk("trap_illegal", 32'(illegal_o), 32'd1);
      chk("trap_minstret", minstret_o, exp_cnt);
    end
    do_reset("post_trap");
    run_instr("after_trap", 32'h00100093, 1'b0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
